// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - column-serial AES MixColumns engine sharing one mixCol network.
// Optional MIXCOL_INV_EN adds in_inv and pre-conditioning so the same network yields InvMixColumns.
module mix_columns_seq #(
  parameter int NCOL  = 4,
  parameter int COL_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCOL*COL_W-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCOL*COL_W-1:0]   out_data,
  output logic                    busy
`ifdef MIXCOL_INV_EN
  , input  logic                  in_inv
`endif
);

  if (NCOL != 4 || COL_W != 32) begin : g_bad_cfg
    $error("mix_columns_seq supports only NCOL=4, COL_W=32");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q;
  logic [1:0]   col_cnt_q;
  logic [127:0] src_q;
  logic [127:0] out_data_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         inv_q;
  logic [31:0]  col_in;
  logic [31:0]  col_pre;
  logic [31:0]  col_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIXCOL_INV_EN
  // InvMixColumns = MixColumns applied to this pre-conditioned column
  function automatic logic [31:0] inv_pre(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t0, t1;
    {a0, a1, a2, a3} = c;
    t0 = xt(xt(a0 ^ a2));
    t1 = xt(xt(a1 ^ a3));
    return {a0 ^ t0, a1 ^ t1, a2 ^ t0, a3 ^ t1};
  endfunction
`endif

  always_comb begin
    col_in = 32'h0;
    case (col_cnt_q)
      2'd0: col_in = src_q[127:96];
      2'd1: col_in = src_q[95:64];
      2'd2: col_in = src_q[63:32];
      2'd3: col_in = src_q[31:0];
      default: col_in = 32'h0;
    endcase
`ifdef MIXCOL_INV_EN
    col_pre = inv_q ? inv_pre(col_in) : col_in;
`else
    col_pre = col_in;
`endif
    col_d = mix_col(col_pre);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      src_q       <= 128'h0;
      out_data_q  <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q      <= in_data;
`ifdef MIXCOL_INV_EN
            inv_q      <= in_inv;
`endif
            col_cnt_q  <= 2'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          case (col_cnt_q)
            2'd0: out_data_q[127:96] <= col_d;
            2'd1: out_data_q[95:64]  <= col_d;
            2'd2: out_data_q[63:32]  <= col_d;
            default: out_data_q[31:0] <= col_d;
          endcase
          col_cnt_q <= col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            col_cnt_q   <= 2'd0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - scoreboard bench for mix_columns_seq with directed FIPS-197 vectors.
// Define MIXCOL_INV_EN to also exercise the inverse path.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
`ifdef MIXCOL_INV_EN
  logic         in_inv = 1'b0;
`endif

  localparam logic [127:0] VA_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VA_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VB_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] VB_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef MIXCOL_INV_EN
    , .in_inv  (in_inv)
`endif
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_acc = 0;
  logic         ov_prev = 1'b0;
  logic [127:0] cur_exp = 128'h0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard push on imminent accept, pop/compare on each output transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (out_valid && !ov_prev)
        chk("latency", 128'(cyc - last_acc), 128'd4);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("wait_ready_timeout", 128'd0, 128'd1);
  endtask

  task automatic issue(input logic [127:0] d, input logic [127:0] e);
    in_valid = 1'b1;
    in_data  = d;
    cur_exp  = e;
    wait_ready();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || out_valid) chk("drain_timeout", 128'd0, 128'd1);
  endtask

  logic [127:0] hold;

  initial begin
    // 1: reset
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    tick();

    // 2: FIPS-197 vector
    out_ready = 1'b1;
    issue(VA_IN, VA_OUT);
    chk("busy_after_accept", 128'(busy), 128'd1);
    chk("in_ready_after_accept", 128'(in_ready), 128'd0);
    drain();

    // 3: backpressure
    out_ready = 1'b0;
    issue(VA_IN, VA_OUT);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    hold     = out_data;
    in_valid = 1'b1;
    in_data  = VB_IN;
    cur_exp  = VB_OUT;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", out_data, hold);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_busy", 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    wait_ready();
    tick();
    in_valid = 1'b0;
    drain();

    // 4: back-to-back, accepts 6 edges apart
    acc_q.delete();
    in_valid = 1'b1;
    in_data  = VA_IN;
    cur_exp  = VA_OUT;
    wait_ready();
    tick();
    in_data  = VB_IN;
    cur_exp  = VB_OUT;
    wait_ready();
    tick();
    in_valid = 1'b0;
    drain();
    chk("b2b_accepts", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2)
      chk("b2b_interval", 128'(acc_q[1] - acc_q[0]), 128'd6);

    // 5: reset after column 1 has been written
    issue(VB_IN, VB_OUT);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_valid", 128'(out_valid), 128'd0);
    end
    issue(VA_IN, VA_OUT);
    drain();

`ifdef MIXCOL_INV_EN
    // 6: inverse path, then forward again with in_inv=0
    in_inv = 1'b1;
    issue(VA_OUT, VA_IN);
    drain();
    in_inv = 1'b0;
    issue(VB_IN, VB_OUT);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
